stage_id: RTL and testbench
===========================

// Module: stage_id
// PURPOSE
//   Registered decode stage feeding stage_ex. Accepts one 32-bit RV32I ALU instruction per cycle,
//   drives register-file read addresses, forwards the EX result combinationally, and latches
//   alusel/aluop/op1/op2/write/regw_addr into the ID/EX register. Supported: OP, OP-IMM, LUI;
//   all other opcodes issue a bubble.
// PARAMETERS
//   XLEN      32  datapath width (fixed at 32; RV32I only)
//   REG_AW    5   register address width
// PORTS
//   clk          in   1      clock, all state on rising edge
//   reset_n      in   1      asynchronous active-low reset
//   inst_valid   in   1      inst holds an instruction to decode
//   inst         in   32     instruction word
//   inst_ready   out  1      = ~stall_i; instruction consumed when inst_valid & inst_ready
//   stall_i      in   1      downstream hold; ID/EX register frozen while high
//   rs1_addr     out  5      regfile read port 1 address (combinational from inst[19:15])
//   rs2_addr     out  5      regfile read port 2 address (combinational from inst[24:20])
//   rs1_data     in   32     regfile read data 1 (same cycle)
//   rs2_data     in   32     regfile read data 2 (same cycle)
//   ex_write     in   1      stage_ex write_o
//   ex_regw_addr in   5      stage_ex regw_addr_o
//   ex_regw_data in   32     stage_ex regw_data
//   alusel       out  3      001 logic, 010 shift, 100 arith, 000 bubble
//   aluop        out  3      logic 0 OR/1 AND/2 XOR; shift 0 SLL/1 SRL/2 SRA; arith 0 ADD/1 SUB/2 SLT/3 SLTU
//   op1, op2     out  32     EX operands
//   write_o      out  1      EX result to be written back
//   regw_addr    out  5      destination register
//   out_valid    out  1      ID/EX register holds a real instruction
//   illegal      out  1      one-cycle pulse: consumed instruction was undecodable
// BEHAVIOUR
//   - Reset (async, reset_n=0): every registered output 0 (alusel=000, write_o=0, out_valid=0, illegal=0).
//   - Latency 1: instruction accepted at edge N appears on ID/EX outputs after edge N.
//   - stall_i=1: all registered outputs hold (illegal forced 0), inst not consumed; stall_i wins over everything.
//   - stall_i=0, inst_valid=0: load bubble (out_valid=0, write_o=0, alusel=000, aluop/op1/op2/regw_addr=0).
//   - Operand read: x0 reads 0; else if ex_write & ex_regw_addr==rs, use ex_regw_data; else rsN_data.
//     Same-cycle writeback bypass inside the regfile is the regfile's job.
//   - OP (0110011): op1=rs1, op2=rs2. funct3/funct7: 000/00 ADD, 000/20 SUB, 001/00 SLL, 010/00 SLT,
//     011/00 SLTU, 100/00 XOR, 101/00 SRL, 101/20 SRA, 110/00 OR, 111/00 AND.
//   - OP-IMM (0010011): op1=rs1, op2=sign-extended imm[11:0]; ADDI/SLTI/SLTIU/XORI/ORI/ANDI.
//     SLLI/SRLI/SRAI: op2={27'b0, shamt}; funct7 must be 00 (20 allowed only for SRAI).
//   - LUI (0110111): arith ADD, op1=0, op2={inst[31:12],12'b0}.
//   - write_o=1 for decoded instructions with rd!=0; rd=0 -> write_o=0, out_valid=1, regw_addr=0.
//   - Undecodable opcode or funct7: bubble loaded, out_valid=0, illegal=1 for one cycle.
//   - Reset mid-stall or mid-stream: outputs clear immediately; held instruction is discarded.
// TESTING
//   1. reset_n=0 with inst_valid=1 -> all outputs 0; release -> first instruction decodes 1 cycle later.
//   2. ADDI x1,x0,5 (0x00500093) -> alusel=100 aluop=0 op1=0 op2=5 write_o=1 regw_addr=1.
//   3. ADDI x1,x0,5 then ADD x2,x1,x1 with regfile x1=0 -> 2nd cycle op1=op2=5 via EX forwarding.
//   4. SRAI x3,x4,3 (0x40325193) -> alusel=010 aluop=2 op2=3; SUB x5,x6,x7 -> alusel=100 aluop=1.
//   5. Issue XOR, assert stall_i 3 cycles with new inst -> outputs frozen, inst_ready=0; drop -> new inst next cycle.
//   6. Opcode 0x0000007F, then ADD x0,x1,x2 -> illegal pulse + bubble; then out_valid=1, write_o=0.

Source files
------------

// File: rtl/stage_id_if.sv
// Instruction handoff from fetch into the decode stage: valid/ready handshake
// carrying one 32-bit instruction word per transfer.
interface stage_id_if;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;

    modport master (output inst_valid, output inst, input inst_ready);
    modport slave  (input inst_valid, input inst, output inst_ready);
endinterface

// File: rtl/stage_id.sv
// RV32I decode stage for OP / OP-IMM / LUI: reads operands with EX forwarding
// and registers the ALU select, opcode, operands and writeback target for EX.
module stage_id #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    stage_id_if.slave         fetch,
    input  logic              stall_i,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              ex_write,
    input  logic [REG_AW-1:0] ex_regw_addr,
    input  logic [XLEN-1:0]   ex_regw_data,
    output logic [2:0]        alusel,
    output logic [2:0]        aluop,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic              write_o,
    output logic [REG_AW-1:0] regw_addr,
    output logic              out_valid,
    output logic              illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [2:0] SEL_LOGIC  = 3'b001;
    localparam logic [2:0] SEL_SHIFT  = 3'b010;
    localparam logic [2:0] SEL_ARITH  = 3'b100;
    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    logic [6:0]              opcode;
    logic [REG_AW-1:0]       rd;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [XLEN-1:0]         rs1_val_p0;
    logic [XLEN-1:0]         rs2_val_p0;
    logic signed [XLEN-1:0]  imm_i_p0;
    logic [XLEN-1:0]         shamt_p0;
    logic [XLEN-1:0]         imm_u_p0;
    logic                    dec_ok_p0;
    logic [2:0]              sel_p0;
    logic [2:0]              op_p0;
    logic [XLEN-1:0]         op1_p0;
    logic [XLEN-1:0]         op2_p0;

    // x0 is hardwired zero and must never pick up a forwarded EX result.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_data,
        input logic              fwd_en,
        input logic [REG_AW-1:0] fwd_addr,
        input logic [XLEN-1:0]   fwd_data
    );
        if (addr == '0)
            return '0;
        else if (fwd_en && (fwd_addr == addr))
            return fwd_data;
        else
            return rf_data;
    endfunction

    assign opcode   = fetch.inst[6:0];
    assign rd       = fetch.inst[11:7];
    assign funct3   = fetch.inst[14:12];
    assign rs1_addr = fetch.inst[19:15];
    assign rs2_addr = fetch.inst[24:20];
    assign funct7   = fetch.inst[31:25];

    assign fetch.inst_ready = ~stall_i;

    assign rs1_val_p0 = read_operand(rs1_addr, rs1_data, ex_write, ex_regw_addr, ex_regw_data);
    assign rs2_val_p0 = read_operand(rs2_addr, rs2_data, ex_write, ex_regw_addr, ex_regw_data);
    assign imm_i_p0   = {{(XLEN-12){fetch.inst[31]}}, fetch.inst[31:20]};
    assign shamt_p0   = {{(XLEN-5){1'b0}}, fetch.inst[24:20]};
    assign imm_u_p0   = {fetch.inst[31:12], 12'b0};

    always_comb begin
        dec_ok_p0 = 1'b0;
        sel_p0    = 3'b000;
        op_p0     = 3'd0;
        op1_p0    = rs1_val_p0;
        op2_p0    = rs2_val_p0;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        dec_ok_p0 = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        sel_p0    = SEL_ARITH;
                        op_p0     = (funct7 == F7_ALT) ? 3'd1 : 3'd0;
                    end
                    3'b001: begin dec_ok_p0 = (funct7 == F7_BASE); sel_p0 = SEL_SHIFT; op_p0 = 3'd0; end
                    3'b010: begin dec_ok_p0 = (funct7 == F7_BASE); sel_p0 = SEL_ARITH; op_p0 = 3'd2; end
                    3'b011: begin dec_ok_p0 = (funct7 == F7_BASE); sel_p0 = SEL_ARITH; op_p0 = 3'd3; end
                    3'b100: begin dec_ok_p0 = (funct7 == F7_BASE); sel_p0 = SEL_LOGIC; op_p0 = 3'd2; end
                    3'b101: begin
                        dec_ok_p0 = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        sel_p0    = SEL_SHIFT;
                        op_p0     = (funct7 == F7_ALT) ? 3'd2 : 3'd1;
                    end
                    3'b110: begin dec_ok_p0 = (funct7 == F7_BASE); sel_p0 = SEL_LOGIC; op_p0 = 3'd0; end
                    default: begin dec_ok_p0 = (funct7 == F7_BASE); sel_p0 = SEL_LOGIC; op_p0 = 3'd1; end
                endcase
            end
            OPC_OP_IMM: begin
                op2_p0    = imm_i_p0;
                dec_ok_p0 = 1'b1;
                case (funct3)
                    3'b000: begin sel_p0 = SEL_ARITH; op_p0 = 3'd0; end
                    3'b010: begin sel_p0 = SEL_ARITH; op_p0 = 3'd2; end
                    3'b011: begin sel_p0 = SEL_ARITH; op_p0 = 3'd3; end
                    3'b100: begin sel_p0 = SEL_LOGIC; op_p0 = 3'd2; end
                    3'b110: begin sel_p0 = SEL_LOGIC; op_p0 = 3'd0; end
                    3'b111: begin sel_p0 = SEL_LOGIC; op_p0 = 3'd1; end
                    3'b001: begin
                        dec_ok_p0 = (funct7 == F7_BASE);
                        sel_p0    = SEL_SHIFT;
                        op_p0     = 3'd0;
                        op2_p0    = shamt_p0;
                    end
                    default: begin
                        dec_ok_p0 = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        sel_p0    = SEL_SHIFT;
                        op_p0     = (funct7 == F7_ALT) ? 3'd2 : 3'd1;
                        op2_p0    = shamt_p0;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_ok_p0 = 1'b1;
                sel_p0    = SEL_ARITH;
                op_p0     = 3'd0;
                op1_p0    = '0;
                op2_p0    = imm_u_p0;
            end
            default: dec_ok_p0 = 1'b0;
        endcase
    end

    // ---- ID/EX register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alusel    <= 3'b000;
            aluop     <= 3'd0;
            op1       <= '0;
            op2       <= '0;
            write_o   <= 1'b0;
            regw_addr <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (stall_i) begin
            illegal <= 1'b0;
        end else if (fetch.inst_valid && dec_ok_p0) begin
            alusel    <= sel_p0;
            aluop     <= op_p0;
            op1       <= op1_p0;
            op2       <= op2_p0;
            write_o   <= (rd != '0);
            regw_addr <= rd;
            out_valid <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            alusel    <= 3'b000;
            aluop     <= 3'd0;
            op1       <= '0;
            op2       <= '0;
            write_o   <= 1'b0;
            regw_addr <= '0;
            out_valid <= 1'b0;
            illegal   <= fetch.inst_valid;
        end
    end

endmodule

// File: tb/tb_stage_id.sv
// Scoreboard bench for stage_id: each driven cycle pushes the hand-derived
// ID/EX contents, which are popped and compared one cycle later.
module tb_stage_id;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_write;
    logic [4:0]  ex_regw_addr;
    logic [31:0] ex_regw_data;
    logic [2:0]  alusel, aluop;
    logic [31:0] op1, op2;
    logic        write_o;
    logic [4:0]  regw_addr;
    logic        out_valid;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  sel;
        logic [2:0]  op;
        logic [31:0] o1;
        logic [31:0] o2;
        logic        wr;
        logic [4:0]  rd;
        logic        vld;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    logic [31:0] rf [32];

    stage_id_if fetch ();

    stage_id dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch        (fetch.slave),
        .stall_i      (stall_i),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .ex_write     (ex_write),
        .ex_regw_addr (ex_regw_addr),
        .ex_regw_data (ex_regw_data),
        .alusel       (alusel),
        .aluop        (aluop),
        .op1          (op1),
        .op2          (op2),
        .write_o      (write_o),
        .regw_addr    (regw_addr),
        .out_valid    (out_valid),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rs1_data = rf[rs1_addr];
        rs2_data = rf[rs2_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".alusel"},    {29'd0, alusel},    {29'd0, e.sel});
        check({tag, ".aluop"},     {29'd0, aluop},     {29'd0, e.op});
        check({tag, ".op1"},       op1,                e.o1);
        check({tag, ".op2"},       op2,                e.o2);
        check({tag, ".write_o"},   {31'd0, write_o},   {31'd0, e.wr});
        check({tag, ".regw_addr"}, {27'd0, regw_addr}, {27'd0, e.rd});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e.vld});
        check({tag, ".illegal"},   {31'd0, illegal},   {31'd0, e.ill});
    endtask

    function automatic exp_t mk(input logic [2:0] sel, input logic [2:0] op,
                                input logic [31:0] o1, input logic [31:0] o2,
                                input logic wr, input logic [4:0] rd,
                                input logic vld, input logic ill);
        exp_t e;
        e.sel = sel; e.op = op; e.o1 = o1; e.o2 = o2;
        e.wr = wr; e.rd = rd; e.vld = vld; e.ill = ill;
        return e;
    endfunction

    // One clock: apply inputs, check combinational outputs, push the expected
    // register contents, then pop and compare just after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic stall, input logic exw, input logic [4:0] exa,
                        input logic [31:0] exd, input exp_t e);
        exp_t got;
        fetch.inst_valid = v;
        fetch.inst       = ins;
        stall_i          = stall;
        ex_write         = exw;
        ex_regw_addr     = exa;
        ex_regw_data     = exd;
        #1;
        check({tag, ".inst_ready"}, {31'd0, fetch.inst_ready}, {31'd0, ~stall});
        check({tag, ".rs1_addr"},   {27'd0, rs1_addr},         {27'd0, ins[19:15]});
        check({tag, ".rs2_addr"},   {27'd0, rs2_addr},         {27'd0, ins[24:20]});
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_out(tag, got);
    endtask

    function automatic exp_t held(input exp_t e);
        exp_t h;
        h = e;
        h.ill = 1'b0;
        return h;
    endfunction

    exp_t zero_e;
    exp_t xor_e;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'h0;
        zero_e = mk(3'b000, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset held with a valid instruction present
        reset_n = 1'b0;
        stall_i = 1'b0;
        fetch.inst_valid = 1'b1;
        fetch.inst = 32'h0050_0093;
        ex_write = 1'b0; ex_regw_addr = 5'd0; ex_regw_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", zero_e);
        reset_n = 1'b1;

        step("addi_x1_5", 1'b1, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b100, 3'd0, 32'd0, 32'd5, 1'b1, 5'd1, 1'b1, 1'b0));
        step("add_fwd", 1'b1, 32'h0010_8133, 1'b0, 1'b1, 5'd1, 32'd5,
             mk(3'b100, 3'd0, 32'd5, 32'd5, 1'b1, 5'd2, 1'b1, 1'b0));
        step("x0_nofwd", 1'b1, 32'h0050_0093, 1'b0, 1'b1, 5'd0, 32'h55,
             mk(3'b100, 3'd0, 32'd0, 32'd5, 1'b1, 5'd1, 1'b1, 1'b0));
        step("srai", 1'b1, 32'h4032_5193, 1'b0, 1'b1, 5'd9, 32'h99,
             mk(3'b010, 3'd2, 32'h104, 32'd3, 1'b1, 5'd3, 1'b1, 1'b0));
        step("sub", 1'b1, 32'h4073_02B3, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b100, 3'd1, 32'h106, 32'h107, 1'b1, 5'd5, 1'b1, 1'b0));
        step("sltu_fwd2", 1'b1, 32'h0031_30B3, 1'b0, 1'b1, 5'd3, 32'h77,
             mk(3'b100, 3'd3, 32'h102, 32'h77, 1'b1, 5'd1, 1'b1, 1'b0));
        step("addi_neg", 1'b1, 32'hFFF2_8213, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b100, 3'd0, 32'h105, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1, 1'b0));
        step("srli_31", 1'b1, 32'h01F0_D113, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b010, 3'd1, 32'h0, 32'd31, 1'b1, 5'd2, 1'b1, 1'b0));
        step("lui", 1'b1, 32'hABCD_E3B7, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b100, 3'd0, 32'h0, 32'hABCD_E000, 1'b1, 5'd7, 1'b1, 1'b0));

        // XOR then three stalled cycles with a different instruction offered
        xor_e = mk(3'b001, 3'd2, 32'h109, 32'h10A, 1'b1, 5'd8, 1'b1, 1'b0);
        step("xor", 1'b1, 32'h00A4_C433, 1'b0, 1'b0, 5'd0, 32'd0, xor_e);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 1'b1, 32'h00D6_65B3, 1'b1, 1'b0, 5'd0, 32'd0, held(last_exp));
        step("or_after_stall", 1'b1, 32'h00D6_65B3, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b001, 3'd0, 32'h10C, 32'h10D, 1'b1, 5'd11, 1'b1, 1'b0));

        step("bad_opcode", 1'b1, 32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b000, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1));
        step("add_rd0", 1'b1, 32'h0020_8033, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b100, 3'd0, 32'd0, 32'h102, 1'b0, 5'd0, 1'b1, 1'b0));
        step("slli_f7_20", 1'b1, 32'h4000_1093, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b000, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1));
        // Illegal on stall: pulse must drop while everything else holds
        step("stall_after_ill", 1'b1, 32'h0000_007F, 1'b1, 1'b0, 5'd0, 32'd0, held(last_exp));
        step("op_f7_01", 1'b1, 32'h0200_0033, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(3'b000, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1));
        step("idle_bubble", 1'b0, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0, zero_e);

        // Asynchronous reset in the middle of a stall clears immediately
        step("xor_again", 1'b1, 32'h00A4_C433, 1'b0, 1'b0, 5'd0, 32'd0, xor_e);
        fetch.inst_valid = 1'b1;
        stall_i = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_out("reset_mid_stall", zero_e);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("after_reset_held", 1'b1, 32'h00A4_C433, 1'b1, 1'b0, 5'd0, 32'd0, zero_e);
        step("after_reset_go", 1'b1, 32'h00A4_C433, 1'b0, 1'b0, 5'd0, 32'd0, xor_e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
